dmux_stream_router: RTL

- Buffered, handshaked 1-to-2 demultiplexer stage, downstream of the combinational Dmux.
- Accepts one data word per transfer on a valid/ready input and steers it by `in_sel` into one of two per-output FIFOs.
- Each output drains independently on its own valid/ready port.
- Lets the two consumers stall without losing data and without blocking traffic bound for the other channel once it is buffered.

---
 rtl/dmux_router_pkg.sv | 14 +
 rtl/dmux_router_fifo.sv | 65 ++++++
 rtl/dmux_stream_router.sv | 89 ++++++++
 3 files changed

// File: rtl/dmux_router_pkg.sv
// rtl/dmux_router_pkg.sv - shared constants and helpers for the buffered 1-to-2 stream router
// Optional statistics counters are enabled with DMUX_ROUTER_STATS_EN.
package dmux_router_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int STAT_W = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmux_router_fifo.sv
// rtl/dmux_router_fifo.sv - single-channel first-word-fall-through FIFO for the stream router
// Output data is forced to zero whenever the FIFO is empty.
module dmux_router_fifo
    import dmux_router_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign full  = (r_count == FULL_CNT);
    assign valid = (r_count != '0);
    assign data  = valid ? r_mem[r_rd_ptr] : '0;

    // Space freed by a same-cycle pop is not reusable until the next cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmux_stream_router.sv
// rtl/dmux_stream_router.sv - buffered handshaked 1-to-2 demultiplexer with per-output FIFOs
// Define DMUX_ROUTER_STATS_EN to add per-channel output handshake counters.
module dmux_stream_router
    import dmux_router_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [WIDTH-1:0]  out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [WIDTH-1:0]  out1_data
`ifdef DMUX_ROUTER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat0_cnt,
    output logic [STAT_W-1:0] stat1_cnt
`endif
);

    logic [1:0] w_full;
    logic       w_fire;
    logic       w_push0;
    logic       w_push1;

    assign in_ready = !w_full[in_sel];
    assign w_fire   = in_valid && in_ready;
    assign w_push0  = w_fire && (in_sel == CH0);
    assign w_push1  = w_fire && (in_sel == CH1);

    dmux_router_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push0),
        .push_data (in_data),
        .full      (w_full[CH0]),
        .pop       (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data)
    );

    dmux_router_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push1),
        .push_data (in_data),
        .full      (w_full[CH1]),
        .pop       (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data)
    );

`ifdef DMUX_ROUTER_STATS_EN
    logic [STAT_W-1:0] r_stat0;
    logic [STAT_W-1:0] r_stat1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                r_stat0 <= r_stat0 + 1'b1;
            end
            if (out1_valid && out1_ready) begin
                r_stat1 <= r_stat1 + 1'b1;
            end
        end
    end

    assign stat0_cnt = r_stat0;
    assign stat1_cnt = r_stat1;
`endif

endmodule
